// File: rtl/dial_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// dial_cmd_sequencer
//
// Front-end controller for the dial rotation datapath. Parses an ASCII byte
// stream of lines such as "L68" / "R48" into signed rotations and issues each
// one to the dial core over a valid/ready handshake. The dial core integrates
// rot_n_o every cycle, so rot_n_o is forced to zero whenever no rotation is
// being offered. End of input and malformed input are reported as sticky
// flags.
//
// Ports
//   clk_i        sole clock, rising edge
//   reset_i      synchronous, active-high reset
//   in_valid_i   in_data_i holds a byte
//   in_ready_o   block accepts a byte this cycle (IDLE and NUM only)
//   in_data_i    ASCII byte
//   in_last_i    qualifies the final byte of the input (with in_valid_i)
//   rot_valid_o  rot_n_o holds a rotation
//   rot_ready_i  dial core accepts the rotation (may be tied high)
//   rot_n_o      signed rotation: R -> +value, L -> -value, 0 when idle
//   rot_count_o  rotations handshaken since reset, wraps modulo 2^CNT_W
//   busy_o       state is NUM or ISSUE
//   done_o       input fully consumed and all rotations issued (sticky)
//   err_o        malformed input or magnitude overflow (sticky)
//
// State        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for a direction letter; CR/LF are skipped
// S_NUM        | collecting decimal digits of the magnitude
// S_ISSUE      | offering the rotation, held until rot_ready_i
// S_DONE       | input finished, every rotation issued; absorbing
// S_ERR        | malformed input seen; absorbing
// ---------------------------------------------------------------------------
module dial_cmd_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        in_data_i,
  input  logic              in_last_i,
  output logic              rot_valid_o,
  input  logic              rot_ready_i,
  output logic [DATA_W-1:0] rot_n_o,
  output logic [CNT_W-1:0]  rot_count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NUM   = 3'd1,
    S_ISSUE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  // Four extra bits hold acc*10 + 9 for any acc below 2^(DATA_W-1) without
  // truncation, so the overflow compare sees the true value.
  localparam int PW = DATA_W + 4;
  localparam logic [PW-1:0] ACC_MAX = {5'b00000, {(DATA_W-1){1'b1}}};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                dir_q, dir_d;          // 1 = R (positive)
  logic                has_dig_q, has_dig_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                in_ready_q;
  logic                rot_valid_q;
  logic [DATA_W-1:0]   rot_n_q, rot_n_d;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic                is_digit;
  logic                is_dir;
  logic                is_eol;
  logic [PW-1:0]       acc_ext;
  logic [PW-1:0]       acc_wide;
  logic                acc_ovf;

  assign is_digit = (in_data_i >= CH_0) && (in_data_i <= CH_9);
  assign is_dir   = (in_data_i == CH_L) || (in_data_i == CH_R);
  assign is_eol   = (in_data_i == CH_LF) || (in_data_i == CH_CR);

  // acc*10 as (acc<<3) + (acc<<1); the ASCII digit's low nibble is its value.
  assign acc_ext  = {4'b0000, acc_q};
  assign acc_wide = (acc_ext << 3) + (acc_ext << 1)
                  + {{(PW-4){1'b0}}, in_data_i[3:0]};
  assign acc_ovf  = (acc_wide > ACC_MAX);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    dir_d     = dir_q;
    has_dig_d = has_dig_q;
    last_d    = last_q;
    count_d   = count_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (is_dir) begin
            acc_d     = '0;
            has_dig_d = 1'b0;
            last_d    = 1'b0;
            dir_d     = (in_data_i == CH_R);
            // A direction letter as the final byte leaves a line with no digits.
            state_d   = in_last_i ? S_ERR : S_NUM;
          end else if (is_eol) begin
            if (in_last_i) state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_NUM: begin
        if (in_valid_i) begin
          if (is_digit) begin
            if (acc_ovf) begin
              state_d = S_ERR;
            end else begin
              acc_d     = acc_wide[DATA_W-1:0];
              has_dig_d = 1'b1;
              if (in_last_i) begin
                last_d  = 1'b1;
                state_d = S_ISSUE;
              end
            end
          end else if (in_data_i == CH_CR) begin
            if (in_last_i) begin
              if (has_dig_q) begin
                last_d  = 1'b1;
                state_d = S_ISSUE;
              end else begin
                state_d = S_ERR;
              end
            end
          end else if (in_data_i == CH_LF) begin
            if (has_dig_q) begin
              last_d  = in_last_i;
              state_d = S_ISSUE;
            end else begin
              state_d = S_ERR;
            end
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_ISSUE: begin
        if (rot_ready_i) begin
          count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = last_q ? S_DONE : S_IDLE;
        end
      end

      default: begin
        state_d = state_q;
      end
    endcase
  end

  // The offered value is computed from next-state so it appears on the same
  // edge that enters ISSUE and drops to zero on the handshake edge.
  always_comb begin
    rot_n_d = '0;
    if (state_d == S_ISSUE) begin
      rot_n_d = dir_d ? acc_d : ('0 - acc_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      dir_q       <= 1'b0;
      has_dig_q   <= 1'b0;
      last_q      <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      rot_valid_q <= 1'b0;
      rot_n_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      dir_q       <= dir_d;
      has_dig_q   <= has_dig_d;
      last_q      <= last_d;
      count_q     <= count_d;
      in_ready_q  <= (state_d == S_IDLE) || (state_d == S_NUM);
      rot_valid_q <= (state_d == S_ISSUE);
      rot_n_q     <= rot_n_d;
      busy_q      <= (state_d == S_NUM) || (state_d == S_ISSUE);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign rot_valid_o = rot_valid_q;
  assign rot_n_o     = rot_n_q;
  assign rot_count_o = count_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dial_cmd_sequencer.sv
module tb_dial_cmd_sequencer;

  localparam int W  = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                in_valid, in_last, rot_ready;
  logic [7:0]          in_data;
  logic                in_ready, rot_valid, busy, done, err;
  logic signed [W-1:0] rot_n;
  logic [CW-1:0]       rot_count;

  logic                in_valid8, in_last8, rot_ready8;
  logic [7:0]          in_data8;
  logic                in_ready8, rot_valid8, busy8, done8, err8;
  logic signed [7:0]   rot_n8;
  logic [CW-1:0]       rot_count8;

  dial_cmd_sequencer #(.DATA_W(W), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .rot_valid_o(rot_valid),
    .rot_ready_i(rot_ready), .rot_n_o(rot_n), .rot_count_o(rot_count),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  dial_cmd_sequencer #(.DATA_W(8), .CNT_W(CW)) dut8 (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .in_data_i(in_data8), .in_last_i(in_last8), .rot_valid_o(rot_valid8),
    .rot_ready_i(rot_ready8), .rot_n_o(rot_n8), .rot_count_o(rot_count8),
    .busy_o(busy8), .done_o(done8), .err_o(err8)
  );

  int      total = 0;
  int      bad   = 0;
  byte     stim_q[$];
  longint  exp_q[$];
  longint  got_q[$];
  int      exp_end;      // 0 idle, 1 done, 2 err
  int      n_acc;
  int      viol;
  int      valid_cycles;
  longint  dial_pos = 50;
  bit      prev_stall = 0;
  longint  prev_n = 0;
  int      rdy_mode = 0; // 0 tied high, 1 random, 3 left to the test
  bit      gaps = 0;
  int      seen8;
  int      val8;

  // Passive observer: records handshakes, integrates like the dial core,
  // and counts protocol violations for the tests to inspect.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (rot_valid) valid_cycles++;
      if (rot_valid && rot_ready) got_q.push_back(longint'(rot_n));
      if (!rot_valid && rot_n != 0) viol++;
      if (prev_stall && (!rot_valid || longint'(rot_n) != prev_n)) viol++;
      prev_stall = rot_valid && !rot_ready;
      prev_n     = longint'(rot_n);
    end
    dial_pos = (((dial_pos + longint'(rot_n)) % 100) + 100) % 100;
  end

  initial begin
    rot_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) rot_ready = 1'b1;
      else if (rdy_mode == 1) rot_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // '^' in a stimulus string stands for a carriage return.
  task automatic load(input string s);
    byte c;
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h5E) c = 8'h0D;
      stim_q.push_back(c);
    end
  endtask

  // Reference: apply the line grammar directly to the byte list.
  task automatic model(input bit use_last, input int w);
    longint acc, maxv;
    bit in_num, has, neg, last;
    byte c;
    int len;
    exp_q.delete();
    exp_end = 0; n_acc = 0;
    maxv = (longint'(1) << (w - 1)) - 1;
    in_num = 0; acc = 0; has = 0; neg = 0;
    len = stim_q.size();
    for (int i = 0; i < len; i++) begin
      c = stim_q[i];
      last = use_last && (i == len - 1);
      n_acc = i + 1;
      if (!in_num) begin
        if (c == "L" || c == "R") begin
          in_num = 1; acc = 0; has = 0; neg = (c == "L");
          if (last) begin exp_end = 2; break; end
        end else if (c == 8'h0A || c == 8'h0D) begin
          if (last) begin exp_end = 1; break; end
        end else begin
          exp_end = 2; break;
        end
      end else begin
        if (c >= "0" && c <= "9") begin
          acc = acc * 10 + longint'(c - "0");
          if (acc > maxv) begin exp_end = 2; break; end
          has = 1;
          if (last) begin exp_q.push_back(neg ? -acc : acc); exp_end = 1; break; end
        end else if (c == 8'h0D) begin
          if (last) begin
            if (has) begin exp_q.push_back(neg ? -acc : acc); exp_end = 1; end
            else exp_end = 2;
            break;
          end
        end else if (c == 8'h0A) begin
          if (!has) begin exp_end = 2; break; end
          exp_q.push_back(neg ? -acc : acc);
          in_num = 0;
          if (last) begin exp_end = 1; break; end
        end else begin
          exp_end = 2; break;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_valid8 = 1'b0; in_last8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic drive_bytes(input int n, input bit use_last, output bit ok);
    int to, g;
    bit acc_b;
    ok = 1;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = stim_q[i];
      in_last  = use_last && (i == int'(stim_q.size()) - 1);
      to = 0; acc_b = 0;
      while (!acc_b) begin
        @(negedge clk);
        acc_b = in_ready;
        @(posedge clk); #1;
        if (!acc_b) begin
          to++;
          if (to > 200) begin ok = 0; break; end
        end
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (!ok) break;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  function automatic bit end_reached();
    case (exp_end)
      1:       return done;
      2:       return err;
      default: return in_ready && !rot_valid;
    endcase
  endfunction

  task automatic run_stream(input string name, input string s, input bit use_last);
    bit ok, reached;
    int base_cnt, t;
    load(s);
    model(use_last, W);
    got_q.delete(); viol = 0; valid_cycles = 0;
    base_cnt = int'(rot_count);
    drive_bytes(n_acc, use_last, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s accept: byte not accepted within 200 cycles", name); end
    t = 0; reached = 0;
    while (!reached && t < 300) begin
      @(negedge clk);
      reached = (got_q.size() >= exp_q.size()) && end_reached();
      t++;
    end
    total++;
    if (!reached) begin bad++; $display("FAIL %s finish: end state %0d not reached in 300 cycles", name, exp_end); end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s issued: got %0d rotations, expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++;
        if (got_q[i] != exp_q[i]) begin
          bad++; $display("FAIL %s rot[%0d]: got %0d expected %0d", name, i, got_q[i], exp_q[i]);
        end
      end
    end
    total++;
    if (done !== (exp_end == 1)) begin bad++; $display("FAIL %s done: got %b expected %b", name, done, exp_end == 1); end
    total++;
    if (err !== (exp_end == 2)) begin bad++; $display("FAIL %s err: got %b expected %b", name, err, exp_end == 2); end
    total++;
    if (in_ready !== (exp_end == 0)) begin bad++; $display("FAIL %s in_ready: got %b expected %b", name, in_ready, exp_end == 0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy: got %b expected 0", name, busy); end
    total++;
    if (rot_count !== CW'(base_cnt + exp_q.size())) begin
      bad++; $display("FAIL %s rot_count: got %0d expected %0d", name, rot_count, CW'(base_cnt + exp_q.size()));
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL %s protocol: %0d zero/hold violations, expected 0", name, viol); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    total++; if (rot_valid !== 1'b0) begin bad++; $display("FAIL reset rot_valid: got %b expected 0", rot_valid); end
    total++; if (rot_n !== 0)        begin bad++; $display("FAIL reset rot_n: got %0d expected 0", rot_n); end
    total++; if (rot_count !== 0)    begin bad++; $display("FAIL reset rot_count: got %0d expected 0", rot_count); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset done: got %b expected 0", done); end
    total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset err: got %b expected 0", err); end
  endtask

  task automatic test_basic();
    do_reset(); rdy_mode = 0; gaps = 0;
    run_stream("basic", "L68\nL30\nR48\n", 1'b1);
    total++;
    if (valid_cycles != 3) begin bad++; $display("FAIL basic valid_cycles: got %0d expected 3", valid_cycles); end
  endtask

  task automatic test_last_digit();
    do_reset(); rdy_mode = 0; gaps = 0;
    run_stream("lastdig", "R14^\n\nL82", 1'b1);
  endtask

  task automatic test_stall();
    bit ok;
    int hold_bad;
    do_reset(); rdy_mode = 3; rot_ready = 1'b0; gaps = 0;
    load("L5\n");
    drive_bytes(3, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall accept: got not-accepted expected accepted"); end
    hold_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!(rot_valid === 1'b1 && rot_n === -5 && in_ready === 1'b0)) hold_bad++;
      @(posedge clk); #1;
    end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL stall hold: %0d bad cycles, expected 0", hold_bad); end
    rot_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || rot_valid !== 1'b1) begin
      bad++; $display("FAIL stall pre_hs: in_ready=%b rot_valid=%b expected 0/1", in_ready, rot_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rot_valid !== 1'b0 || rot_n !== 0 || in_ready !== 1'b1 || rot_count !== 1) begin
      bad++; $display("FAIL stall post_hs: valid=%b n=%0d in_ready=%b count=%0d expected 0/0/1/1",
                      rot_valid, rot_n, in_ready, rot_count);
    end
    rdy_mode = 0;
  endtask

  task automatic test_errors();
    int hold_bad;
    rdy_mode = 0; gaps = 0;
    do_reset(); run_stream("err_x",   "X1\n", 1'b0);
    do_reset(); run_stream("err_nod", "L\n", 1'b0);
    hold_bad = 0;
    in_valid = 1'b1; in_data = "R";
    repeat (5) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || err !== 1'b1 || rot_valid !== 1'b0) hold_bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (hold_bad != 0) begin bad++; $display("FAIL err_sticky: %0d bad cycles, expected 0", hold_bad); end
    do_reset(); run_stream("ovf_min",  "R2147483648\n", 1'b0);
    do_reset(); run_stream("ovf_wide", "R4294967300\n", 1'b0);
    do_reset(); run_stream("max_ok",   "L2147483647\n", 1'b0);
    do_reset(); run_stream("err_last", "R5X", 1'b1);
    do_reset(); run_stream("cr_last",  "R5^", 1'b1);
    do_reset(); run_stream("dir_last", "L", 1'b1);
  endtask

  task automatic drive8(input string s);
    int to;
    bit acc_b, stop;
    seen8 = 0; val8 = 0; stop = 0;
    rot_ready8 = 1'b1; in_last8 = 1'b0;
    for (int i = 0; i < s.len() && !stop; i++) begin
      in_valid8 = 1'b1; in_data8 = s[i];
      to = 0; acc_b = 0;
      while (!acc_b && to < 50) begin
        @(negedge clk);
        if (rot_valid8) begin seen8++; val8 = int'(rot_n8); end
        if (err8) begin stop = 1; break; end
        acc_b = in_ready8;
        @(posedge clk); #1;
        to++;
      end
    end
    in_valid8 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rot_valid8) begin seen8++; val8 = int'(rot_n8); end
    end
  endtask

  task automatic test_width8();
    do_reset();
    drive8("R128\n");
    total++; if (err8 !== 1'b1)     begin bad++; $display("FAIL w8_ovf err: got %b expected 1", err8); end
    total++; if (seen8 != 0)        begin bad++; $display("FAIL w8_ovf issued: got %0d expected 0", seen8); end
    total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL w8_ovf in_ready: got %b expected 0", in_ready8); end
    do_reset();
    drive8("R127\n");
    total++; if (seen8 != 1 || val8 != 127) begin bad++; $display("FAIL w8_max: got %0d issues value %0d expected 1 issue value 127", seen8, val8); end
    total++;
    if (err8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0 || rot_count8 !== 1) begin
      bad++; $display("FAIL w8_max flags: err=%b done=%b busy=%b count=%0d expected 0/0/0/1", err8, done8, busy8, rot_count8);
    end
  endtask

  task automatic test_reset_mid_issue();
    bit ok;
    do_reset(); rdy_mode = 3; rot_ready = 1'b0; gaps = 0;
    load("R7\n");
    drive_bytes(3, 1'b0, ok);
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (rot_valid !== 1'b1) begin bad++; $display("FAIL midrst staged: rot_valid got %b expected 1", rot_valid); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rot_valid !== 1'b0 || rot_n !== 0 || rot_count !== 0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst drop: valid=%b n=%0d count=%0d in_ready=%b expected 0/0/0/1",
                      rot_valid, rot_n, rot_count, in_ready);
    end
    reset = 1'b0;
    rot_ready = 1'b1; rdy_mode = 0;
    @(posedge clk); #1;
    run_stream("midrst_after", "R60\n", 1'b0);
  endtask

  task automatic test_sample();
    do_reset(); rdy_mode = 0; gaps = 0;
    dial_pos = 50;
    run_stream("sample", "L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82", 1'b1);
    total++; if (rot_count !== 10) begin bad++; $display("FAIL sample count: got %0d expected 10", rot_count); end
    total++; if (dial_pos != 32)   begin bad++; $display("FAIL sample dial_pos: got %0d expected 32", dial_pos); end
  endtask

  task automatic test_random();
    string s, d;
    int nl, k;
    bit use_last;
    for (int it = 0; it < 25; it++) begin
      do_reset(); rdy_mode = 1; gaps = 1;
      s = "";
      nl = $urandom_range(1, 6);
      for (int l = 0; l < nl; l++) begin
        d = ($urandom_range(0, 1) == 1) ? "R" : "L";
        k = $urandom_range(0, 19);
        case (k)
          0:       s = {s, d, "1Z\n"};
          1:       s = {s, "\n"};
          2:       s = {s, d, $sformatf("%0d", $urandom_range(0, 99)), "^\n"};
          3:       s = {s, d, $sformatf("%0d", $urandom), "\n"};
          4:       s = {s, d, "\n"};
          default: s = {s, d, $sformatf("%0d", $urandom_range(0, 999)), "\n"};
        endcase
      end
      use_last = 1'($urandom_range(0, 1));
      if (use_last && s.len() > 1 && $urandom_range(0, 1) == 1) s = s.substr(0, s.len() - 2);
      run_stream($sformatf("rand%0d", it), s, use_last);
    end
    rdy_mode = 0; gaps = 0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    in_valid8 = 1'b0; in_last8 = 1'b0; in_data8 = 8'h00; rot_ready8 = 1'b1;
    test_reset();
    test_basic();
    test_last_digit();
    test_stall();
    test_errors();
    test_width8();
    test_reset_mid_issue();
    test_sample();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dial_cmd_sequencer.md
# dial_cmd_sequencer

Front-end controller for the dial rotation datapath. Accepts the puzzle input as an ASCII byte stream (lines such as `L68`, `R48`), parses each line into a signed rotation and issues it to the dial core over a valid/ready handshake. The dial core integrates its `n` input every cycle, so this block drives zero on `rot_n` whenever no rotation is being issued. It also flags end-of-input and malformed input.

## Interface
- `DATA_W`, default 32: width of the signed rotation sent to the dial core.
- `CNT_W`, default 16: width of the issued-rotation counter.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: `in_data` holds a byte.
- `in_ready` out 1: block can accept a byte this cycle.
- `in_data` in 8: ASCII byte.
- `in_last` in 1: qualifies the final byte of the input, valid with `in_valid`.
- `rot_valid` out 1: `rot_n` holds a rotation.
- `rot_ready` in 1: dial core accepts the rotation. May be tied high.
- `rot_n` out `DATA_W`, signed: R gives +value, L gives −value. Equals 0 whenever `rot_valid` = 0.
- `rot_count` out `CNT_W`: number of rotations handshaken since reset. Wraps modulo 2^`CNT_W`.
- `busy` out 1: state is neither IDLE nor DONE nor ERR.
- `done` out 1: input fully consumed and every rotation issued. Sticky.
- `err` out 1: malformed input detected. Sticky.

## Operation
- Byte accepted when `in_valid` & `in_ready`. `in_ready` = 1 only in IDLE and NUM.
- States: IDLE (waiting for direction), NUM (collecting digits), ISSUE, DONE, ERR.
- IDLE:
  - 'L' (0x4C) or 'R' (0x52): acc ← 0, digits ← 0, dir latched, go to NUM.
  - 0x0A or 0x0D: ignored (blank lines, CRLF).
  - Any other byte: go to ERR.
- NUM:
  - '0'–'9': acc ← acc·10 + d, digits set.
  - 0x0D: ignored.
  - 0x0A with digits ≥ 1: go to ISSUE.
  - 0x0A with no digits, or any other byte: go to ERR.
- Overflow: if acc·10 + d > 2^(`DATA_W`−1) − 1, go to ERR. This is checked on the full-width product, without truncation.
- ISSUE:
  - `rot_valid` = 1 and `rot_n` = dir ? acc : −acc, both held stable until `rot_ready`.
  - On handshake: `rot_count` increments, then go to DONE if last was seen, else IDLE.
- `in_last` handling, applied after the byte itself is processed:
  - In IDLE: go to DONE.
  - In NUM with digits ≥ 1: set last_seen and go to ISSUE; the final line needs no newline.
  - In NUM with no digits: go to ERR.
  - If the last byte is a 0x0A that triggers ISSUE: last_seen is set.
- DONE and ERR are absorbing until `reset`. `in_ready` = 0 and `rot_valid` = 0 in both.
- ERR has priority: a byte that is both illegal and `in_last` goes to ERR, not DONE.

## Timing
- Reset values: state IDLE, `in_ready` 1, `rot_valid` 0, `rot_n` 0, `rot_count` 0, `busy` 0, `done` 0, `err` 0, acc 0.
- `reset` mid-operation: any pending rotation is dropped. After the reset edge, `rot_valid` = 0 and `rot_n` = 0 with no partial issue.
- Terminating byte (0x0A, or a last digit with `in_last`) accepted at edge t: `rot_valid` = 1 from t+1.
- Handshake at edge t+k: `rot_valid` = 0, `rot_n` = 0 and `in_ready` = 1 from t+k+1.
- Minimum cost per rotation line of b bytes with `rot_ready` tied high: b + 1 cycles.
- `rot_count` updates on the handshake edge. `done` or `err` rises on the edge that enters the state.
- All outputs are registered, or decoded from state only. No combinational path from `in_*` or `rot_ready` to any output.

## Test plan
- Stream "L68\nL30\nR48\n" with `rot_ready` = 1 → `rot_n` −68, −30, +48, each for exactly one cycle; `rot_count` = 3; `rot_n` = 0 in every other cycle.
- Stream "R14\r\n\nL82" with `in_last` on '2' → +14 then −82 issued, then `done` = 1, `in_ready` = 0, `busy` = 0.
- "L5\n" with `rot_ready` low for 4 cycles → `rot_valid` and `rot_n` = −5 held for 4 cycles. `in_ready` stays 0 until the cycle after the handshake.
- "X1\n", "L\n", and with `DATA_W` = 8 "R128\n" → `err` = 1 in each case, no rotation issued, `in_ready` = 0 until reset.
- Assert `reset` while in ISSUE with `rot_ready` = 0 → next cycle `rot_valid` = 0, `rot_count` = 0. Then "R60\n" → +60 issued normally.
- Full 10-line sample "L68 L30 R48 L5 R60 L55 L1 L99 R14 L82" feeding the dial core → `rot_count` = 10, `done` = 1. Dial core reports the same position and count as when driven directly with those rotations.
